// File: rtl/serial_tx_pkg.sv
// Purpose: shared state encoding and default framing constants for the serial tx/rx pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_tx_pkg;

   // Frame phases; the matching receiver walks the same sequence
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

   // Counter width for a modulo-n counter; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Purpose: per-bit cycle counter, counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Latency: tick is decoded from the registered count, so it is valid in the same cycle.
// Backpressure: none; clear holds the count at zero.
module bit_timer
   import serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Count cycles within a bit, wrapping on the bit boundary
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // With CLKS_PER_BIT=1 the count sits at 0 and every cycle ends a bit
   assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Purpose: parallel-to-serial line transmitter, framing: start(0), DATA_W bits LSB first, stop(1).
// Latency: frame starts the edge after an accepted load; (DATA_W+2)*CLKS_PER_BIT cycles per frame.
// Backpressure: ready is high only in IDLE; load while ready is low is dropped.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] din,
   input  logic              load,
   output logic              ready,
   output logic              busy,
   output logic              txd
);

   // Wide enough to hold DATA_W so the count never wraps inside a frame
   localparam int            BW       = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
   logic              tick;
   logic              timer_clr;

   // Timer is held clear while idle so START always begins at count 0
   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clr),
      .tick    (tick)
   );

   // State, shift register and bit counter; reset wins over any load
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Next-state and line outputs, decoded only from registered state
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      ready       = 1'b0;
      busy        = 1'b0;
      txd         = 1'b1;
      timer_clr   = 1'b0;
      case (state)
         IDLE: begin
            ready     = 1'b1;
            timer_clr = 1'b1;
            if (load) begin
               state_nxt   = START;
               shreg_nxt   = din;
               bit_cnt_nxt = '0;
            end
         end
         START: begin
            busy = 1'b1;
            txd  = 1'b0;
            if (tick) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            busy = 1'b1;
            txd  = shreg[0];
            if (tick) begin
               shreg_nxt   = shreg >> 1;
               bit_cnt_nxt = bit_cnt + BW'(1);
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            busy = 1'b1;
            if (tick) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
